// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage next-PC sequencer: branch encodings
// and the redirect sources arbitrated by the priority mux.
package pc_pkg;

  localparam logic [1:0] BR_NONE    = 2'b00;
  localparam logic [1:0] BR_TAKEN_A = 2'b01;
  localparam logic [1:0] BR_TAKEN_B = 2'b10;

  typedef enum logic [2:0] {
    TRAP,
    HOLD,
    BRANCH,
    RET,
    JUMP,
    SEQ
  } pc_src_e;

  // 2'b11 is deliberately a not-taken encoding
  function automatic logic branch_taken(input logic [1:0] br);
    return (br == BR_TAKEN_A) || (br == BR_TAKEN_B);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect bundle between decode/branch resolution and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);

  logic                         stall;
  logic                         trap;
  logic [1:0]                   branch;
  logic [WIDTH-1:0]             branch_target;
  logic                         jump_reg;
  logic [WIDTH-1:0]             jump_target;
  logic                         call;
  logic                         ret;
  logic [WIDTH-1:0]             pc;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_underflow;

  modport master (
    output stall, trap, branch, branch_target, jump_reg, jump_target, call, ret,
    input  pc, ras_count, ras_underflow
  );

  modport slave (
    input  stall, trap, branch, branch_target, jump_reg, jump_target, call, ret,
    output pc, ras_count, ras_underflow
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_top_ptr;
  logic [PW:0]      r_count;
  logic [PW-1:0]    w_push_ptr;
  logic             w_do_pop;

  assign w_push_ptr = r_top_ptr + PW'(1);
  assign w_do_pop   = pop && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_top_ptr <= '0;
      r_count   <= '0;
    end else if (push) begin
      r_top_ptr <= w_push_ptr;
      r_count   <= (r_count == FULL) ? r_count : r_count + (PW+1)'(1);
    end else if (w_do_pop) begin
      r_top_ptr <= r_top_ptr - PW'(1);
      r_count   <= r_count - (PW+1)'(1);
    end
  end

  // Storage has no reset: entries are only read while r_count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[w_push_ptr] <= push_data;
    end
  end

  assign top   = r_mem[r_top_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC register for the fetch stage: trap/stall/branch/return/jump/sequential
// priority mux with a return-address stack for call/return pairs.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      STEP        = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [31:0]      TRAP_VECTOR = 32'h0000_0080,
  parameter int unsigned      RAS_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  pc_src_e                    w_src;
  logic [WIDTH-1:0]           r_pc;
  logic [WIDTH-1:0]           w_pc_next;
  logic [WIDTH-1:0]           w_pc_inc;
  logic [WIDTH-1:0]           w_ras_top;
  logic [$clog2(RAS_DEPTH):0] w_ras_count;
  logic                       w_ras_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       r_underflow;
  logic                       w_underflow_next;

  assign w_pc_inc = r_pc + WIDTH'(STEP);

  always_comb begin
    w_src = SEQ;
    if (bus.trap)                          w_src = TRAP;
    else if (bus.stall)                    w_src = HOLD;
    else if (branch_taken(bus.branch))     w_src = BRANCH;
    else if (bus.ret)                      w_src = RET;
    else if (bus.jump_reg)                 w_src = JUMP;
  end

  always_comb begin
    w_pc_next        = w_pc_inc;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_underflow_next = 1'b0;
    case (w_src)
      TRAP:   w_pc_next = WIDTH'(TRAP_VECTOR);
      HOLD:   w_pc_next = r_pc;
      BRANCH: w_pc_next = bus.branch_target;
      RET: begin
        // Empty stack falls back to the register target and flags the miss
        if (w_ras_empty) begin
          w_pc_next        = bus.jump_target;
          w_underflow_next = 1'b1;
        end else begin
          w_pc_next = w_ras_top;
          w_pop     = 1'b1;
        end
      end
      JUMP: begin
        w_pc_next = bus.jump_target;
        w_push    = bus.call;
      end
      default: w_pc_next = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_underflow <= w_underflow_next;
    end
  end

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .count     (w_ras_count),
    .empty     (w_ras_empty)
  );

  assign bus.pc            = r_pc;
  assign bus.ras_count     = w_ras_count;
  assign bus.ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 32-bit instance under directed and random
// control traffic, plus an 8-bit instance exercising wrap and trap truncation.
module tb_pc_sequencer;

  logic clk;
  logic reset;

  pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) if_m ();
  pc_sequencer_if #(.WIDTH(8),  .RAS_DEPTH(2)) if_s ();

  pc_sequencer #(
    .WIDTH       (32),
    .STEP        (4),
    .RESET_PC    (32'h0),
    .TRAP_VECTOR (32'h0000_0080),
    .RAS_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_m)
  );

  pc_sequencer #(
    .WIDTH       (8),
    .STEP        (4),
    .RESET_PC    (8'hF0),
    .TRAP_VECTOR (32'h0000_0180),
    .RAS_DEPTH   (2)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    int unsigned cnt;
    bit          uf;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp8_q[$];

  // Reference model: pc value, stack as a bounded queue (back = most recent call)
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic [7:0]  s_pc;
  bit          s8_stall;
  bit          s8_trap;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, predict, return at the next falling edge
  task automatic cyc(input bit st, input bit tr, input logic [1:0] br, input logic [31:0] bt,
                     input bit jr, input logic [31:0] jt, input bit cl, input bit rt);
    exp_t        e;
    logic [31:0] np;
    bit          u;
    bit          taken;
    if_m.stall = st; if_m.trap = tr; if_m.branch = br; if_m.branch_target = bt;
    if_m.jump_reg = jr; if_m.jump_target = jt; if_m.call = cl; if_m.ret = rt;
    if_s.stall = s8_stall; if_s.trap = s8_trap;

    u     = 1'b0;
    taken = (br == 2'b01) || (br == 2'b10);
    if (tr)            np = 32'h80;
    else if (st)       np = m_pc;
    else if (taken)    np = bt;
    else if (rt) begin
      if (m_ras.size() > 0) np = m_ras.pop_back();
      else begin
        np = jt;
        u  = 1'b1;
      end
    end else if (jr) begin
      if (cl) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      np = jt;
    end else           np = m_pc + 32'd4;
    m_pc  = np;
    e.pc  = np;
    e.cnt = m_ras.size();
    e.uf  = u;
    exp_q.push_back(e);

    if (s8_trap)        s_pc = 8'h80;
    else if (!s8_stall) s_pc = s_pc + 8'd4;
    exp8_q.push_back(s_pc);

    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic zero_inputs();
    if_m.stall = 1'b0; if_m.trap = 1'b0; if_m.branch = 2'b00; if_m.branch_target = '0;
    if_m.jump_reg = 1'b0; if_m.jump_target = '0; if_m.call = 1'b0; if_m.ret = 1'b0;
    if_s.stall = 1'b0; if_s.trap = 1'b0; if_s.branch = 2'b00; if_s.branch_target = '0;
    if_s.jump_reg = 1'b0; if_s.jump_target = '0; if_s.call = 1'b0; if_s.ret = 1'b0;
  endtask

  // Reset asserted mid-cycle, optionally with a call already on the inputs
  task automatic do_reset(input bit inflight);
    if (inflight) begin
      if_m.jump_reg = 1'b1; if_m.call = 1'b1; if_m.jump_target = 32'h200;
    end
    #2 reset = 1'b1;
    #1;
    chk("reset pc", if_m.pc, 32'h0);
    chk("reset ras_count", 32'(if_m.ras_count), 32'h0);
    chk("reset ras_underflow", 32'(if_m.ras_underflow), 32'h0);
    chk("reset pc8", 32'(if_s.pc), 32'hF0);
    exp_q.delete();
    exp8_q.delete();
    m_ras.delete();
    m_pc = 32'h0;
    s_pc = 8'hF0;
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every output update is compared against the oldest prediction
  initial begin
    exp_t       e;
    logic [7:0] e8;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pc", if_m.pc, e.pc);
          chk("ras_count", 32'(if_m.ras_count), e.cnt);
          chk("ras_underflow", 32'(if_m.ras_underflow), 32'(e.uf));
        end
        if (exp8_q.size() > 0) begin
          e8 = exp8_q.pop_front();
          chk("pc8", 32'(if_s.pc), 32'(e8));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bt;
    logic [31:0] jt;
    logic [1:0]  br;
    reset    = 1'b0;
    s8_stall = 1'b0;
    s8_trap  = 1'b0;
    m_pc     = 32'h0;
    s_pc     = 8'hF0;
    zero_inputs();
    @(negedge clk);
    do_reset(1'b0);

    idle();
    chk("idle pc 1", if_m.pc, 32'h4);
    idle();
    chk("idle pc 2", if_m.pc, 32'h8);
    do_reset(1'b1);

    idle(); idle(); idle();
    chk("idle pc 3", if_m.pc, 32'hC);
    chk("pc8 before wrap", 32'(if_s.pc), 32'hFC);
    idle();
    chk("pc8 wrap", 32'(if_s.pc), 32'h00);

    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0);
    chk("call pc", if_m.pc, 32'h200);
    chk("call count", 32'(if_m.ras_count), 32'h1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'hDEAD0, 1'b0, 1'b1);
    chk("ret pc", if_m.pc, 32'h14);
    chk("ret count", 32'(if_m.ras_count), 32'h0);

    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b10, 32'h100, 1'b1, 32'h300, 1'b0, 1'b0);
    chk("branch over jump", if_m.pc, 32'h100);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b11, 32'h100, 1'b1, 32'h300, 1'b0, 1'b0);
    chk("branch 11 not taken", if_m.pc, 32'h300);

    do_reset(1'b0);
    for (int unsigned k = 0; k < 5; k++)
      cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, (k + 1) << 8, 1'b1, 1'b0);
    chk("ras saturate", 32'(if_m.ras_count), 32'h4);
    for (int unsigned k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'hF00, 1'b0, 1'b1);
      chk("ras pop order", if_m.pc, 32'h404 - (k << 8));
    end
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'hF00, 1'b0, 1'b1);
    chk("underflow pc", if_m.pc, 32'hF00);
    chk("underflow pulse", 32'(if_m.ras_underflow), 32'h1);
    idle();
    chk("underflow clears", 32'(if_m.ras_underflow), 32'h0);

    cyc(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 32'h700, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall hold pc", if_m.pc, 32'h500);
    chk("stall hold ras", 32'(if_m.ras_count), 32'h1);
    cyc(1'b1, 1'b1, 2'b01, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("trap over stall", if_m.pc, 32'h80);
    chk("trap keeps ras", 32'(if_m.ras_count), 32'h1);

    repeat (600) begin
      s8_stall = ($urandom_range(0, 3) == 0);
      s8_trap  = ($urandom_range(0, 15) == 0);
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), br, bt,
          ($urandom_range(0, 3) == 0), jt, ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 4) == 0));
    end

    s8_stall = 1'b0;
    s8_trap  = 1'b0;
    idle();
    idle();
    @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    chk("scoreboard8 drained", 32'(exp8_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-PC register for the pipeline fetch stage. It generalises the fixed 32-bit branch/jump/increment PC update with configurable width, step and reset vector. It adds a trap redirect and a return-address stack (RAS) that serves call/return pairs. It sits between the decode/branch-resolution logic and instruction memory and drives the fetch address every cycle.

## Interface
- WIDTH, 32, PC and target width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_PC, 0, PC value on reset.
- TRAP_VECTOR, 32'h0000_0080, redirect address on trap (truncated to WIDTH).
- RAS_DEPTH, 4, return-stack entries; power of two, ≥2.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  hold PC and RAS this cycle.
- trap  in  1  redirect to TRAP_VECTOR.
- branch  in  2  taken when 2'b01 or 2'b10; 2'b00/2'b11 not taken.
- branch_target  in  WIDTH  branch destination.
- jump_reg  in  1  unconditional jump to jump_target.
- jump_target  in  WIDTH  jump destination; also fallback for empty-RAS return.
- call  in  1  qualifies jump_reg: push pc+STEP.
- ret  in  1  return: redirect to RAS top and pop.
- pc  out  WIDTH  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_underflow  out  1  one-cycle pulse: ret seen with empty RAS.

## Operation
- Priority each cycle, highest first: trap > stall > branch taken > ret > jump_reg > sequential.
- trap: pc ← TRAP_VECTOR. This applies even when stall=1. RAS is unchanged.
- stall (no trap): pc holds. No push or pop. ras_underflow=0.
- branch taken: pc ← branch_target. call, ret and jump_reg are ignored.
- ret (ret=1 and no branch taken):
  - RAS non-empty: pc ← top entry, then pop.
  - RAS empty: pc ← jump_target and ras_underflow=1 for one cycle.
  - If ret and jump_reg are both high, ret wins and call is ignored.
- jump_reg: pc ← jump_target.
  - If call=1 as well, push pc+STEP. The pushed value is the current pc register plus STEP.
- call without jump_reg has no effect.
- Sequential: pc ← pc+STEP.
- Arithmetic: all additions are modulo 2^WIDTH. An all-ones PC wraps to STEP-1.
- RAS is circular with a top pointer.
  - Push when full (ras_count=RAS_DEPTH) overwrites the oldest entry. ras_count saturates at RAS_DEPTH.
  - Pop decrements ras_count, which saturates at 0.
- Reset values: pc=RESET_PC, ras_count=0, ras_underflow=0, top pointer=0. RAS storage contents are don't-care.

## Timing
- All outputs are registered and update on the rising edge of clk. Inputs are sampled at that same edge.
- Redirect latency is 1 cycle: inputs applied in cycle N produce the new pc in cycle N+1.
- A ret in the cycle after a call returns the address just pushed; there is no bubble.
- reset asserts asynchronously and forces the reset values immediately, mid-operation included. An in-flight push or pop is discarded.
- On the first rising edge after reset deasserts, normal priority evaluation applies.

## Structure
- Package pc_pkg holds:
  - branch encoding constants BR_NONE=2'b00, BR_TAKEN_A=2'b01, BR_TAKEN_B=2'b10.
  - a localparam or enum naming the redirect source (TRAP, HOLD, BRANCH, RET, JUMP, SEQ), used by the priority mux.
- Sub-module return_stack, parametrised by WIDTH and RAS_DEPTH:
  - inputs: push, pop, push data.
  - outputs: top, count, empty.
  - handles circular overwrite.
- pc_sequencer keeps the PC register, the priority mux and the underflow pulse.

## Test plan
- Reset then 3 idle cycles → pc = 0x0, 0x4, 0x8, 0xC. Assert reset mid-run at pc=0x8 → pc=0x0 immediately, ras_count=0.
- At pc=0x20, drive branch=2'b10, branch_target=0x100 with jump_reg=1 and jump_target=0x300 → pc=0x100. Repeat with branch=2'b11 → pc=0x300.
- At pc=0x10, drive jump_reg=1, call=1, jump_target=0x200 → pc=0x200, ras_count=1. Next cycle drive ret=1 → pc=0x14, ras_count=0.
- RAS_DEPTH=4: five calls from pcs 0x0, 0x100, 0x200, 0x300, 0x400. Then five rets (jump_target=0xF00):
  - first four rets → 0x404, 0x304, 0x204, 0x104.
  - fifth ret → pc=0xF00 with ras_underflow=1.
- stall=1 with branch=2'b01 → pc unchanged. Add trap=1 in the same cycle → pc=0x80 and ras_count unchanged.
- WIDTH=8, STEP=4, start pc=0xFC, sequential step → pc=0x00 (wrap).
